// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: req/ack handshake, pipeline stall until the access
// completes, MEM/WB register with load data; misaligned/timed-out accesses retire as bubbles.
module mem_access_unit #(
  parameter int word     = 32,
  parameter int rwidth   = 5,
  parameter int MAX_WAIT = 15,
  parameter int TOUT_W   = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic              MEM_MemtoReg,
  input  logic              MEM_RegWrite,
  input  logic [word-1:0]   MEM_ALU_result,
  input  logic [word-1:0]   MEM_MUX6_out,
  input  logic [rwidth-1:0] MEM_MUX8_out,
  output logic              DM_req,
  output logic              DM_we,
  output logic [word-1:0]   DM_addr,
  output logic [word-1:0]   DM_wdata,
  input  logic              DM_ack,
  input  logic [word-1:0]   DM_rdata,
  output logic              Stall,
  output logic              WB_RegWrite,
  output logic              WB_MemtoReg,
  output logic [word-1:0]   WB_ALU_result,
  output logic [word-1:0]   WB_ReadData,
  output logic [rwidth-1:0] WB_MUX8_out,
  output logic              AlignErr,
  output logic              BusErr
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [TOUT_W-1:0] LAST_WAIT = TOUT_W'(MAX_WAIT - 1);

  logic [0:0]        state_q, state_d;
  logic [TOUT_W-1:0] cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [word-1:0]   addr_q, addr_d;
  logic [word-1:0]   wdata_q, wdata_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic              wb_memtoreg_q, wb_memtoreg_d;
  logic [word-1:0]   wb_alu_q, wb_alu_d;
  logic [word-1:0]   wb_rdata_q, wb_rdata_d;
  logic [rwidth-1:0] wb_dst_q, wb_dst_d;
  logic              align_err_q, align_err_d;
  logic              bus_err_q, bus_err_d;
  logic              stall_c;

  logic memop, misaligned, ack_vld;
  assign memop      = MEM_MemRead | MEM_MemWrite;
  assign misaligned = memop & (MEM_ALU_result[1:0] != 2'b00);
  // Ack is only meaningful while a request is outstanding.
  assign ack_vld    = DM_ack & req_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wb_regwrite_d = 1'b0;
    wb_memtoreg_d = 1'b0;
    wb_alu_d      = '0;
    wb_rdata_d    = '0;
    wb_dst_d      = '0;
    align_err_d   = 1'b0;
    bus_err_d     = 1'b0;
    stall_c       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!memop) begin
          wb_regwrite_d = MEM_RegWrite;
          wb_memtoreg_d = MEM_MemtoReg;
          wb_alu_d      = MEM_ALU_result;
          wb_dst_d      = MEM_MUX8_out;
        end else if (misaligned) begin
          align_err_d = 1'b1;
        end else begin
          stall_c = 1'b1;
          req_d   = 1'b1;
          we_d    = ~MEM_MemRead;
          addr_d  = MEM_ALU_result;
          wdata_d = MEM_MUX6_out;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      default: begin
        if (ack_vld) begin
          // Stall drops here so EX/MEM advances on the same edge the result retires.
          req_d         = 1'b0;
          wb_regwrite_d = MEM_RegWrite;
          wb_memtoreg_d = MEM_MemtoReg;
          wb_alu_d      = MEM_ALU_result;
          wb_dst_d      = MEM_MUX8_out;
          wb_rdata_d    = we_q ? '0 : DM_rdata;
          state_d       = S_IDLE;
        end else if (cnt_q < LAST_WAIT) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wb_regwrite_q <= 1'b0;
      wb_memtoreg_q <= 1'b0;
      wb_alu_q      <= '0;
      wb_rdata_q    <= '0;
      wb_dst_q      <= '0;
      align_err_q   <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_memtoreg_q <= wb_memtoreg_d;
      wb_alu_q      <= wb_alu_d;
      wb_rdata_q    <= wb_rdata_d;
      wb_dst_q      <= wb_dst_d;
      align_err_q   <= align_err_d;
      bus_err_q     <= bus_err_d;
    end
  end

  // Pipeline must not freeze while reset is flushing it.
  assign Stall         = stall_c & ~Reset;
  assign DM_req        = req_q;
  assign DM_we         = we_q;
  assign DM_addr       = addr_q;
  assign DM_wdata      = wdata_q;
  assign WB_RegWrite   = wb_regwrite_q;
  assign WB_MemtoReg   = wb_memtoreg_q;
  assign WB_ALU_result = wb_alu_q;
  assign WB_ReadData   = wb_rdata_q;
  assign WB_MUX8_out   = wb_dst_q;
  assign AlignErr      = align_err_q;
  assign BusErr        = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; outputs sampled 1 time unit after each rising edge.
module tb_mem_access_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite;
  logic [31:0] MEM_ALU_result, MEM_MUX6_out;
  logic [4:0]  MEM_MUX8_out;
  logic        DM_req, DM_we, DM_ack;
  logic [31:0] DM_addr, DM_wdata, DM_rdata;
  logic        Stall, WB_RegWrite, WB_MemtoReg, AlignErr, BusErr;
  logic [31:0] WB_ALU_result, WB_ReadData;
  logic [4:0]  WB_MUX8_out;

  int checks = 0;
  int errors = 0;
  int stall_cnt;

  mem_access_unit #(.word(32), .rwidth(5), .MAX_WAIT(15), .TOUT_W(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_MemtoReg(MEM_MemtoReg), .MEM_RegWrite(MEM_RegWrite),
    .MEM_ALU_result(MEM_ALU_result), .MEM_MUX6_out(MEM_MUX6_out),
    .MEM_MUX8_out(MEM_MUX8_out),
    .DM_req(DM_req), .DM_we(DM_we), .DM_addr(DM_addr), .DM_wdata(DM_wdata),
    .DM_ack(DM_ack), .DM_rdata(DM_rdata), .Stall(Stall),
    .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg),
    .WB_ALU_result(WB_ALU_result), .WB_ReadData(WB_ReadData),
    .WB_MUX8_out(WB_MUX8_out), .AlignErr(AlignErr), .BusErr(BusErr)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic m2r, input logic rw,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dst);
    MEM_MemRead    = rd;
    MEM_MemWrite   = wr;
    MEM_MemtoReg   = m2r;
    MEM_RegWrite   = rw;
    MEM_ALU_result = alu;
    MEM_MUX6_out   = wd;
    MEM_MUX8_out   = dst;
  endtask

  initial begin
    Reset = 1'b1;
    DM_ack = 1'b0;
    DM_rdata = 32'h0;
    set_op(1, 0, 0, 0, 32'h10, 32'h0, 5'd0);

    // Reset held two cycles with a pending load on the inputs
    tick(); tick();
    chk("rst_req", DM_req, 0);
    chk("rst_stall", Stall, 0);
    chk("rst_wb_rw", WB_RegWrite, 0);
    chk("rst_wb_alu", WB_ALU_result, 0);
    chk("rst_wb_dst", WB_MUX8_out, 0);
    chk("rst_wb_rd", WB_ReadData, 0);
    chk("rst_addr", DM_addr, 0);
    set_op(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    Reset = 1'b0;
    #1;
    chk("rel_req", DM_req, 0);
    chk("rel_stall", Stall, 0);

    // Non-memory ALU op
    set_op(0, 0, 0, 1, 32'h1234, 32'h0, 5'd7);
    #1;
    chk("alu_stall", Stall, 0);
    tick();
    chk("alu_wb_rw", WB_RegWrite, 1);
    chk("alu_wb_alu", WB_ALU_result, 32'h1234);
    chk("alu_wb_dst", WB_MUX8_out, 7);
    chk("alu_wb_rd", WB_ReadData, 0);
    chk("alu_req", DM_req, 0);

    // Load acked in wait cycle 3
    set_op(1, 0, 1, 1, 32'h40, 32'h0, 5'd3);
    #1;
    chk("ld_stall0", Stall, 1);
    tick();
    chk("ld_req", DM_req, 1);
    chk("ld_addr", DM_addr, 32'h40);
    chk("ld_we", DM_we, 0);
    chk("ld_bub1", WB_RegWrite, 0);
    chk("ld_stall1", Stall, 1);
    tick();
    chk("ld_bub2", WB_RegWrite, 0);
    chk("ld_stall2", Stall, 1);
    tick();
    DM_ack = 1'b1;
    DM_rdata = 32'hDEADBEEF;
    #1;
    chk("ld_stall3", Stall, 0);
    tick();
    DM_ack = 1'b0;
    chk("ld_wb_rd", WB_ReadData, 32'hDEADBEEF);
    chk("ld_wb_m2r", WB_MemtoReg, 1);
    chk("ld_wb_rw", WB_RegWrite, 1);
    chk("ld_wb_dst", WB_MUX8_out, 3);
    chk("ld_req_off", DM_req, 0);

    // Store with immediate ack, then a back-to-back store
    set_op(0, 1, 0, 0, 32'h8, 32'hA5A5A5A5, 5'd0);
    #1;
    chk("st_stall0", Stall, 1);
    tick();
    chk("st_req", DM_req, 1);
    chk("st_we", DM_we, 1);
    chk("st_wdata", DM_wdata, 32'hA5A5A5A5);
    chk("st_addr", DM_addr, 32'h8);
    DM_ack = 1'b1;
    #1;
    chk("st_stall1", Stall, 0);
    tick();
    DM_ack = 1'b0;
    chk("st_req_off", DM_req, 0);
    chk("st_wb_rd", WB_ReadData, 0);
    set_op(0, 1, 0, 0, 32'hC, 32'h12345678, 5'd0);
    #1;
    chk("st2_gap_req", DM_req, 0);
    chk("st2_stall", Stall, 1);
    tick();
    chk("st2_req", DM_req, 1);
    chk("st2_addr", DM_addr, 32'hC);
    chk("st2_wdata", DM_wdata, 32'h12345678);
    DM_ack = 1'b1;
    tick();
    DM_ack = 1'b0;
    chk("st2_req_off", DM_req, 0);
    chk("st2_we_hold", DM_we, 1);

    // Timeout: never acked
    set_op(1, 0, 1, 1, 32'h80, 32'h0, 5'd4);
    stall_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!Stall) break;
      stall_cnt++;
      chk("to_bubble", WB_RegWrite, 0);
      tick();
    end
    chk("to_stall_cycles", stall_cnt, 15);
    chk("to_req_held", DM_req, 1);
    chk("to_buserr_pre", BusErr, 0);
    set_op(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    tick();
    chk("to_buserr", BusErr, 1);
    chk("to_req_off", DM_req, 0);
    chk("to_wb_rw", WB_RegWrite, 0);
    DM_ack = 1'b1;
    set_op(0, 0, 0, 1, 32'h55, 32'h0, 5'd2);
    #1;
    chk("late_stall", Stall, 0);
    tick();
    DM_ack = 1'b0;
    chk("late_buserr", BusErr, 0);
    chk("late_req", DM_req, 0);
    chk("late_wb_alu", WB_ALU_result, 32'h55);
    chk("late_wb_rd", WB_ReadData, 0);

    // Ack in the last allowed wait cycle succeeds
    set_op(1, 0, 1, 1, 32'h84, 32'h0, 5'd9);
    DM_rdata = 32'h0BADF00D;
    tick();
    for (int i = 0; i < 13; i++) tick();
    chk("lw_stall14", Stall, 1);
    tick();
    DM_ack = 1'b1;
    #1;
    chk("lw_stall15", Stall, 0);
    tick();
    DM_ack = 1'b0;
    chk("lw_buserr", BusErr, 0);
    chk("lw_wb_rd", WB_ReadData, 32'h0BADF00D);
    chk("lw_wb_rw", WB_RegWrite, 1);
    chk("lw_req_off", DM_req, 0);

    // Misaligned load
    set_op(1, 0, 1, 1, 32'h42, 32'h0, 5'd5);
    #1;
    chk("mis_stall", Stall, 0);
    tick();
    chk("mis_alignerr", AlignErr, 1);
    chk("mis_req", DM_req, 0);
    chk("mis_wb_rw", WB_RegWrite, 0);
    set_op(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    tick();
    chk("mis_alignerr_off", AlignErr, 0);

    // Reset while waiting, followed by a late ack
    set_op(1, 0, 1, 1, 32'h100, 32'h0, 5'd6);
    tick();
    chk("rw_req", DM_req, 1);
    Reset = 1'b1;
    #1;
    chk("rw_stall", Stall, 0);
    tick();
    chk("rw_req_off", DM_req, 0);
    chk("rw_addr", DM_addr, 0);
    chk("rw_we", DM_we, 0);
    chk("rw_wb_rw", WB_RegWrite, 0);
    chk("rw_wb_dst", WB_MUX8_out, 0);
    Reset = 1'b0;
    set_op(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    DM_ack = 1'b1;
    tick();
    DM_ack = 1'b0;
    chk("rw_late_req", DM_req, 0);
    chk("rw_late_rd", WB_ReadData, 0);
    chk("rw_late_buserr", BusErr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage controller that consumes the EX/MEM pipeline register outputs and drives a handshaked data-memory port. It turns MemRead/MemWrite into a request/acknowledge transaction, stalls the front of the pipeline until the access completes, and registers the MEM/WB pipeline outputs, including load data. Misaligned addresses and unresponsive memory are flagged and retired as bubbles.

## Interface
Parameters:
- word, 32, data and address width
- rwidth, 5, register-number width
- MAX_WAIT, 15, maximum wait cycles for DM_ack before timeout (1..2^TOUT_W-1)
- TOUT_W, 4, wait-counter width

Ports:
- Clock  in  1  sole clock, all state changes on posedge
- Reset  in  1  synchronous, active-high
- MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite  in  1 each  control bits from EX/MEM
- MEM_ALU_result  in  word  address for memory ops, or result for non-memory ops
- MEM_MUX6_out  in  word  store data
- MEM_MUX8_out  in  rwidth  destination register
- DM_req  out  1  memory request, registered
- DM_we  out  1  1 = write, registered
- DM_addr, DM_wdata  out  word  registered, stable while DM_req=1
- DM_ack  in  1  completion, sampled only while DM_req=1
- DM_rdata  in  word  read data, valid with DM_ack on a read
- Stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM
- WB_RegWrite, WB_MemtoReg  out  1  MEM/WB control
- WB_ALU_result, WB_ReadData  out  word  MEM/WB data
- WB_MUX8_out  out  rwidth  MEM/WB destination
- AlignErr, BusErr  out  1  registered one-cycle error pulses

## Operation
- memop = MEM_MemRead | MEM_MemWrite. If both are set, it is treated as a read.
- misaligned = memop & (MEM_ALU_result[1:0] != 0). Only word accesses are supported.
- FSM states: IDLE, WAIT.
- IDLE, no memop:
  - WB_* <= MEM_* (WB_ReadData <= 0).
  - Stall = 0.
- IDLE, misaligned:
  - No request is issued; Stall = 0.
  - AlignErr <= 1.
  - WB bubble: WB_RegWrite <= 0, WB_MemtoReg <= 0, WB data <= 0.
- IDLE, aligned memop:
  - Stall = 1.
  - DM_req <= 1, DM_we <= ~MEM_MemRead, DM_addr <= MEM_ALU_result, DM_wdata <= MEM_MUX6_out.
  - Wait counter <= 0; go to WAIT.
  - WB bubble.
- WAIT, DM_ack = 1:
  - Stall = 0, so EX/MEM advances on the same edge.
  - DM_req <= 0.
  - WB_* <= MEM_* (still held by the stall).
  - WB_ReadData <= DM_rdata if read, else 0.
  - Go to IDLE.
- WAIT, no ack, counter < MAX_WAIT-1:
  - Stall = 1; counter++.
  - WB bubble.
- WAIT, no ack, counter == MAX_WAIT-1:
  - Timeout: Stall = 0, DM_req <= 0, BusErr <= 1.
  - WB bubble; go to IDLE. The instruction is retired without effect.
- AlignErr and BusErr are 0 in every cycle where they are not explicitly set.
- DM_addr, DM_wdata and DM_we hold their values after the request drops.

## Timing
- Reset (any state, including mid-WAIT):
  - state = IDLE, counter = 0.
  - DM_req = DM_we = 0, DM_addr = DM_wdata = 0.
  - All WB_* = 0, AlignErr = BusErr = 0.
  - An outstanding request is abandoned; a late DM_ack is ignored.
- Non-memory instruction: 1 cycle in MEM; WB_* is valid the cycle after EX/MEM presents it.
- Memory op acked in wait cycle k (1 ≤ k ≤ MAX_WAIT):
  - Occupies k+1 cycles in MEM; Stall is high for k cycles.
  - WB outputs are valid the cycle after the ack.
- Ack arriving in IDLE, or when DM_req = 0: ignored.
- Ack in the MAX_WAIT-th wait cycle: counts as success, not a timeout.
- Back-to-back memory ops: the next op enters IDLE the cycle after the ack and issues DM_req one cycle later, so DM_req has a minimum 1-cycle low gap.

## Test plan
- Reset: hold Reset 2 cycles with MEM_MemRead=1, addr 0x10 → DM_req=0, Stall=0, all WB_*=0; release and check no spurious request appears before the first edge.
- ALU op: RegWrite=1, ALU_result=0x1234, MUX8=7 → next cycle WB_RegWrite=1, WB_ALU_result=0x1234, WB_MUX8_out=7, Stall never high.
- Load, ack in wait cycle 3: addr 0x40, DM_rdata=0xDEADBEEF →
  - Stall high 3 cycles.
  - DM_addr=0x40, DM_we=0.
  - Then WB_ReadData=0xDEADBEEF, WB_MemtoReg=1.
  - Bubbles (WB_RegWrite=0) during the stall.
- Store, immediate ack: addr 0x8, data 0xA5A5A5A5 →
  - DM_we=1, DM_wdata=0xA5A5A5A5.
  - Stall high 1 cycle.
  - Back-to-back second store shows the 1-cycle DM_req gap.
- Timeout: MAX_WAIT=15, never ack →
  - Stall high exactly 15 cycles (1 issue + 14 wait).
  - BusErr pulses 1 cycle; WB_RegWrite=0.
  - A late ack is ignored.
  - Second case: ack in wait cycle 15 → success, no BusErr.
- Misaligned and reset mid-WAIT:
  - Load addr 0x42 → AlignErr 1 cycle, no DM_req, no stall.
  - Reset asserted in WAIT → all outputs 0 next cycle.
